uart_cmd_decoder: RTL

- Converts ASCII command characters from the UART receiver into stopwatch control signals.
- Parametrised successor to the single-byte stopwatch command decoder. Adds:
  - a small command FIFO;
  - a ready handshake toward the watch;
  - registered toggle state for pause and count direction;
  - a stop command;
  - unknown-command and overflow reporting.
- Sits between the UART RX datapath and the stopwatch core.

---
 rtl/uart_cmd_decoder_if.sv | 32 +++
 rtl/uart_cmd_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Bundle of the RX-side character strobe, the watch-side ready and every
// stopwatch control output of the command decoder.
interface uart_cmd_decoder_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              watch_ready;
    logic              run;
    logic              pause;
    logic              down;
    logic              clear;
    logic              recv;
    logic              cmd_err;
    logic              overflow;
    logic [CNT_W-1:0]  fifo_count;

    // Source side: UART receiver plus the stopwatch core
    modport master (
        output rx_data, rx_valid, watch_ready,
        input  run, pause, down, clear, recv, cmd_err, overflow, fifo_count
    );

    // Decoder side
    modport slave (
        input  rx_data, rx_valid, watch_ready,
        output run, pause, down, clear, recv, cmd_err, overflow, fifo_count
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder for the stopwatch: buffers received characters in a
// small FIFO, pops one per cycle while the watch is ready and turns each into
// registered level / pulse controls.
module uart_cmd_decoder #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CASE_FOLD  = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_cmd_decoder_if.slave bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [2:0] {
        CMD_CLR,
        CMD_GO,
        CMD_STOP,
        CMD_PAUSE,
        CMD_UP,
        CMD_RECV,
        CMD_ERR
    } cmd_e;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    // Pointers carry one extra MSB so full and empty are distinguishable
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              run_q, run_d;
    logic              pause_q, pause_d;
    logic              down_q, down_d;
    logic              clear_q, clear_d;
    logic              recv_q, recv_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic              empty, full, push, pop;
    logic [DATA_W-1:0] head;
    logic [7:0]        ch;
    cmd_e              cmd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    // Pop decision uses registered state only, so a fresh push never bypasses
    assign pop   = !empty && bus.watch_ready;
    assign push  = bus.rx_valid && (!full || pop);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Classify the head character; anything unrecognised becomes an error
    always_comb begin
        ch = head[7:0];
        if (CASE_FOLD != 0 && ch >= 8'h61 && ch <= 8'h7a)
            ch = ch - 8'h20;
        cmd = CMD_ERR;
        if ((head & ~DATA_W'(8'hff)) == '0) begin
            case (ch)
                8'h43:   cmd = CMD_CLR;
                8'h47:   cmd = CMD_GO;
                8'h53:   cmd = CMD_STOP;
                8'h50:   cmd = CMD_PAUSE;
                8'h55:   cmd = CMD_UP;
                8'h52:   cmd = CMD_RECV;
                default: cmd = CMD_ERR;
            endcase
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow next-state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = bus.rx_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (bus.rx_valid && !push)
            ovf_d = 1'b1;
        count_d = wr_ptr_d - rd_ptr_d;
    end

    // Control outputs: levels hold and pulses drop unless a command pops
    always_comb begin
        run_d   = run_q;
        pause_d = pause_q;
        down_d  = down_q;
        clear_d = 1'b0;
        recv_d  = 1'b0;
        err_d   = 1'b0;
        if (pop) begin
            case (cmd)
                CMD_CLR: begin
                    clear_d = 1'b1;
                    run_d   = 1'b0;
                    pause_d = 1'b0;
                end
                CMD_GO: begin
                    run_d   = 1'b1;
                    pause_d = 1'b0;
                end
                CMD_STOP:  run_d = 1'b0;
                CMD_PAUSE: begin
                    pause_d = ~pause_q;
                    run_d   = 1'b1;
                end
                CMD_UP: begin
                    down_d = ~down_q;
                    run_d  = 1'b1;
                end
                CMD_RECV: begin
                    recv_d = 1'b1;
                    run_d  = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // State register with asynchronous clear of everything, FIFO included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
            pause_q  <= 1'b0;
            down_q   <= 1'b0;
            clear_q  <= 1'b0;
            recv_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            run_q    <= run_d;
            pause_q  <= pause_d;
            down_q   <= down_d;
            clear_q  <= clear_d;
            recv_q   <= recv_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.run        = run_q;
    assign bus.pause      = pause_q;
    assign bus.down       = down_q;
    assign bus.clear      = clear_q;
    assign bus.recv       = recv_q;
    assign bus.cmd_err    = err_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_count = count_q;
endmodule
